ddr_avl_arbiter: RTL and testbench



---
 rtl/ddr_avl_arbiter_if.sv | 61 ++++++
 rtl/ddr_avl_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ddr_avl_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_avl_arbiter_if.sv
// ddr_avl_arbiter_if
//   Avalon-MM local-port bundle between the DDR arbiter and the DDR3
//   controller.
//
//   master modport : the arbiter side (drives requests, reads ready/rdata)
//   slave modport  : the controller side
//
//   Signals
//     avl_ready        controller ready (inverse of waitrequest)
//     avl_burstbegin   first beat of a command
//     avl_write_req    write beat request
//     avl_read_req     read command request
//     avl_addr         burst start word address
//     avl_size         burst length in beats
//     avl_wdata        write beat data
//     avl_be           write beat byte enables
//     avl_rdata        read return data
//     avl_rdata_valid  read return beat strobe (no backpressure)
interface ddr_avl_arbiter_if #(
    parameter int AVL_ADDR_WIDTH = 29,
    parameter int AVL_DATA_WIDTH = 512,
    parameter int AVL_BE_WIDTH   = AVL_DATA_WIDTH / 8,
    parameter int AVL_SIZE_WIDTH = 3
);
    logic                      avl_ready;
    logic                      avl_burstbegin;
    logic                      avl_write_req;
    logic                      avl_read_req;
    logic [AVL_ADDR_WIDTH-1:0] avl_addr;
    logic [AVL_SIZE_WIDTH-1:0] avl_size;
    logic [AVL_DATA_WIDTH-1:0] avl_wdata;
    logic [AVL_BE_WIDTH-1:0]   avl_be;
    logic [AVL_DATA_WIDTH-1:0] avl_rdata;
    logic                      avl_rdata_valid;

    modport master (
        input  avl_ready,
        input  avl_rdata,
        input  avl_rdata_valid,
        output avl_burstbegin,
        output avl_write_req,
        output avl_read_req,
        output avl_addr,
        output avl_size,
        output avl_wdata,
        output avl_be
    );

    modport slave (
        output avl_ready,
        output avl_rdata,
        output avl_rdata_valid,
        input  avl_burstbegin,
        input  avl_write_req,
        input  avl_read_req,
        input  avl_addr,
        input  avl_size,
        input  avl_wdata,
        input  avl_be
    );
endinterface

// File: rtl/ddr_avl_arbiter.sv
// ddr_avl_arbiter
//   Shares the DDR3 Avalon-MM local port between the frame-buffer write path
//   (burst writes) and the frame read-out path (burst read commands).
//   Round-robin arbitration at burst boundaries, write bursts are never
//   interrupted, outstanding read beats are metered against a credit limit,
//   and every returned read beat is tagged with its command's tag.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. valid must not depend on ready; once raised, valid and its
//   payload stay stable until the transfer. ready is combinational from the
//   FSM state and avl_ready. The return path (ret_*) has no backpressure.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     wr_valid/wr_ready        write beat handshake; wr_addr/wr_size held for
//                              the whole burst, wr_data/wr_be per beat
//     rd_valid/rd_ready        read command handshake; rd_addr/rd_size/rd_tag
//     ret_valid/data/tag/last  tagged read return beats
//     avl                      Avalon-MM master bundle to the controller
//     err_size                 pulse: size-0 command consumed and dropped
//     err_unexp                pulse: rdata_valid with no command outstanding
//     dbg_state                FSM state: 0 IDLE, 1 WR, 2 RD
//     dbg_outstanding          read beats currently in flight
module ddr_avl_arbiter #(
    parameter int AVL_ADDR_WIDTH = 29,
    parameter int AVL_DATA_WIDTH = 512,
    parameter int AVL_BE_WIDTH   = AVL_DATA_WIDTH / 8,
    parameter int AVL_SIZE_WIDTH = 3,
    parameter int TAG_WIDTH      = 8,
    parameter int MAX_RD_CMDS    = 8,
    parameter int MAX_RD_BEATS   = 32,
    localparam int OB_W          = $clog2(MAX_RD_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [AVL_ADDR_WIDTH-1:0] wr_addr,
    input  logic [AVL_SIZE_WIDTH-1:0] wr_size,
    input  logic [AVL_DATA_WIDTH-1:0] wr_data,
    input  logic [AVL_BE_WIDTH-1:0]   wr_be,

    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [AVL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [AVL_SIZE_WIDTH-1:0] rd_size,
    input  logic [TAG_WIDTH-1:0]      rd_tag,

    output logic                      ret_valid,
    output logic [AVL_DATA_WIDTH-1:0] ret_data,
    output logic [TAG_WIDTH-1:0]      ret_tag,
    output logic                      ret_last,

    ddr_avl_arbiter_if.master         avl,

    output logic                      err_size,
    output logic                      err_unexp,
    output logic [1:0]                dbg_state,
    output logic [OB_W-1:0]           dbg_outstanding
);
    localparam int PTR_W = $clog2(MAX_RD_CMDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    logic [1:0]                state, state_nxt;
    logic                      last_grant, last_grant_nxt;
    logic [AVL_SIZE_WIDTH-1:0] wr_beat_cnt, wr_beat_cnt_nxt;
    logic [OB_W-1:0]           outstanding_beats;
    logic [AVL_SIZE_WIDTH-1:0] ret_beat_cnt;

    // Tag FIFO: one entry per read command in flight. Pointers carry an
    // extra wrap bit so full and empty can be told apart.
    logic [TAG_WIDTH-1:0]      fifo_tag  [MAX_RD_CMDS];
    logic [AVL_SIZE_WIDTH-1:0] fifo_size [MAX_RD_CMDS];
    logic [PTR_W:0]            wr_ptr, rd_ptr;
    logic                      fifo_empty, fifo_full;
    logic [TAG_WIDTH-1:0]      head_tag;
    logic [AVL_SIZE_WIDTH-1:0] head_size;

    logic [OB_W:0]             credit_sum;
    logic                      rd_eligible;
    logic                      pick_wr, pick_rd;
    logic                      rd_push, ret_pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_tag   = fifo_tag[rd_ptr[PTR_W-1:0]];
    assign head_size  = fifo_size[rd_ptr[PTR_W-1:0]];

    // One bit wider so a full credit pool plus a new command cannot wrap.
    assign credit_sum  = {1'b0, outstanding_beats} + (OB_W + 1)'(rd_size);
    assign rd_eligible = rd_valid && !fifo_full &&
                         (credit_sum <= (OB_W + 1)'(MAX_RD_BEATS));

    // On a tie the side that did not win last time is chosen.
    assign pick_wr = wr_valid && (!rd_eligible || last_grant == GRANT_RD);
    assign pick_rd = rd_eligible && (!wr_valid || last_grant == GRANT_WR);

    // Return path: combinational, no backpressure.
    assign ret_valid = avl.avl_rdata_valid && !fifo_empty;
    assign ret_last  = ret_valid && (ret_beat_cnt == head_size - AVL_SIZE_WIDTH'(1));
    assign ret_tag   = ret_valid ? head_tag : '0;
    assign ret_data  = ret_valid ? avl.avl_rdata : '0;
    assign ret_pop   = ret_last;
    assign err_unexp = avl.avl_rdata_valid && fifo_empty && !rst;

    assign dbg_state       = state;
    assign dbg_outstanding = outstanding_beats;

    always_comb begin
        state_nxt          = state;
        last_grant_nxt     = last_grant;
        wr_beat_cnt_nxt    = wr_beat_cnt;
        wr_ready           = 1'b0;
        rd_ready           = 1'b0;
        err_size           = 1'b0;
        rd_push            = 1'b0;
        avl.avl_burstbegin = 1'b0;
        avl.avl_write_req  = 1'b0;
        avl.avl_read_req   = 1'b0;
        avl.avl_addr       = '0;
        avl.avl_size       = '0;
        avl.avl_wdata      = '0;
        avl.avl_be         = '0;
        case (state)
            ST_IDLE: begin
                if (pick_wr) begin
                    last_grant_nxt = GRANT_WR;
                    // A zero-length burst is swallowed here so it never
                    // reaches the controller.
                    if (wr_size == '0) begin
                        wr_ready = 1'b1;
                        err_size = 1'b1;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end else if (pick_rd) begin
                    last_grant_nxt = GRANT_RD;
                    if (rd_size == '0) begin
                        rd_ready = 1'b1;
                        err_size = 1'b1;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_WR: begin
                wr_ready           = avl.avl_ready;
                avl.avl_write_req  = wr_valid;
                avl.avl_burstbegin = wr_valid && (wr_beat_cnt == '0);
                avl.avl_addr       = wr_addr;
                avl.avl_size       = wr_size;
                avl.avl_wdata      = wr_data;
                avl.avl_be         = wr_be;
                if (wr_valid && avl.avl_ready) begin
                    if (wr_beat_cnt == wr_size - AVL_SIZE_WIDTH'(1)) begin
                        wr_beat_cnt_nxt = '0;
                        state_nxt       = ST_IDLE;
                    end else begin
                        wr_beat_cnt_nxt = wr_beat_cnt + AVL_SIZE_WIDTH'(1);
                    end
                end
            end
            ST_RD: begin
                rd_ready           = avl.avl_ready;
                avl.avl_read_req   = 1'b1;
                avl.avl_burstbegin = 1'b1;
                avl.avl_addr       = rd_addr;
                avl.avl_size       = rd_size;
                if (rd_valid && avl.avl_ready) begin
                    rd_push   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            last_grant        <= GRANT_RD;
            wr_beat_cnt       <= '0;
            outstanding_beats <= '0;
            ret_beat_cnt      <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            wr_beat_cnt <= wr_beat_cnt_nxt;
            // Issue and return in the same cycle net to +rd_size-1.
            outstanding_beats <= outstanding_beats
                                 + (rd_push   ? OB_W'(rd_size) : OB_W'(0))
                                 - (ret_valid ? OB_W'(1)       : OB_W'(0));
            if (rd_push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (ret_pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
            if (ret_valid) begin
                ret_beat_cnt <= ret_last ? '0 : ret_beat_cnt + AVL_SIZE_WIDTH'(1);
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            fifo_tag[wr_ptr[PTR_W-1:0]]  <= rd_tag;
            fifo_size[wr_ptr[PTR_W-1:0]] <= rd_size;
        end
    end
endmodule

// File: tb/tb_ddr_avl_arbiter.sv
module tb_ddr_avl_arbiter;
    localparam int AW        = 29;
    localparam int DW        = 512;
    localparam int BW        = DW / 8;
    localparam int SW        = 3;
    localparam int TW        = 8;
    localparam int MAX_CMDS  = 8;
    localparam int MAX_BEATS = 32;
    localparam int OBW       = $clog2(MAX_BEATS + 1);
    localparam byte G_W      = 8'h57;
    localparam byte G_R      = 8'h52;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_size;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic [TW-1:0] rd_tag;
    logic          ret_valid, ret_last;
    logic [DW-1:0] ret_data;
    logic [TW-1:0] ret_tag;
    logic          err_size, err_unexp;
    logic [1:0]    dbg_state;
    logic [OBW-1:0] dbg_outstanding;

    ddr_avl_arbiter_if #(.AVL_ADDR_WIDTH(AW), .AVL_DATA_WIDTH(DW),
                         .AVL_BE_WIDTH(BW), .AVL_SIZE_WIDTH(SW)) avl_bus ();

    ddr_avl_arbiter #(
        .AVL_ADDR_WIDTH(AW), .AVL_DATA_WIDTH(DW), .AVL_BE_WIDTH(BW),
        .AVL_SIZE_WIDTH(SW), .TAG_WIDTH(TW), .MAX_RD_CMDS(MAX_CMDS),
        .MAX_RD_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_size(wr_size), .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_size(rd_size), .rd_tag(rd_tag),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_tag(ret_tag),
        .ret_last(ret_last),
        .avl(avl_bus.master),
        .err_size(err_size), .err_unexp(err_unexp),
        .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [DW-1:0] got,
                                  input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Model: read commands in flight as {tag,size}, beats in flight, beat
    // index inside the current return command and inside the current write
    // burst, and the order in which commands reached the Avalon port.
    logic [TW+SW-1:0] exp_q[$];
    int               model_out     = 0;
    int               model_ret_cnt = 0;
    int               model_wr_beat = 0;
    byte              grant_log[$];
    logic             exp_ret;
    logic [TW+SW-1:0] head;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_out     = 0;
            model_ret_cnt = 0;
            model_wr_beat = 0;
            check("rst_write_req", avl_bus.avl_write_req, 0);
            check("rst_read_req", avl_bus.avl_read_req, 0);
            check("rst_burstbegin", avl_bus.avl_burstbegin, 0);
            check("rst_wr_ready", wr_ready, 0);
            check("rst_rd_ready", rd_ready, 0);
            check("rst_ret_valid", ret_valid, 0);
            check("rst_err_unexp", err_unexp, 0);
            check("rst_avl_addr", avl_bus.avl_addr, 0);
            check("rst_state", dbg_state, 0);
        end else begin
            exp_ret = avl_bus.avl_rdata_valid && (exp_q.size() > 0);
            check("ret_valid", ret_valid, exp_ret);
            check("err_unexp", err_unexp, avl_bus.avl_rdata_valid && (exp_q.size() == 0));
            check("outstanding", dbg_outstanding, model_out);
            if (exp_ret) begin
                head = exp_q[0];
                check("ret_tag", ret_tag, head[TW+SW-1:SW]);
                check("ret_last", ret_last, model_ret_cnt == int'(head[SW-1:0]) - 1);
                check("ret_data", ret_data, avl_bus.avl_rdata);
            end
            if (avl_bus.avl_write_req) begin
                check("wr_excl_read", avl_bus.avl_read_req, 0);
                check("wr_addr", avl_bus.avl_addr, wr_addr);
                check("wr_size", avl_bus.avl_size, wr_size);
                check("wr_wdata", avl_bus.avl_wdata, wr_data);
                check("wr_be", avl_bus.avl_be, wr_be);
                check("wr_burstbegin", avl_bus.avl_burstbegin, model_wr_beat == 0);
            end
            if (avl_bus.avl_read_req) begin
                check("rd_not_mid_write", model_wr_beat, 0);
                check("rd_addr", avl_bus.avl_addr, rd_addr);
                check("rd_size", avl_bus.avl_size, rd_size);
                check("rd_burstbegin", avl_bus.avl_burstbegin, 1);
                if (avl_bus.avl_ready) begin
                    check("rd_fifo_room", exp_q.size() < MAX_CMDS, 1);
                    check("rd_credit", model_out + int'(rd_size) <= MAX_BEATS, 1);
                end
            end
            // advance the model for the coming edge
            if (exp_ret) begin
                model_out--;
                if (model_ret_cnt == int'(head[SW-1:0]) - 1) begin
                    void'(exp_q.pop_front());
                    model_ret_cnt = 0;
                end else begin
                    model_ret_cnt++;
                end
            end
            if (avl_bus.avl_read_req && avl_bus.avl_ready && rd_valid) begin
                exp_q.push_back({rd_tag, rd_size});
                model_out += int'(rd_size);
                grant_log.push_back(G_R);
            end
            if (avl_bus.avl_write_req && avl_bus.avl_ready) begin
                if (model_wr_beat == 0) grant_log.push_back(G_W);
                model_wr_beat++;
                if (model_wr_beat == int'(wr_size)) model_wr_beat = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_write(input logic [AW-1:0] addr, input logic [SW-1:0] size);
        int beats;
        int done;
        int waited;
        logic hit;
        beats  = (size == 0) ? 1 : int'(size);
        done   = 0;
        waited = 0;
        wr_addr  = addr;
        wr_size  = size;
        wr_data  = rand_data();
        wr_be    = {BW/32{32'($urandom())}};
        wr_valid = 1'b1;
        while (done < beats && waited < 200) begin
            @(negedge clk);
            hit = wr_ready;
            cyc();
            if (hit) begin
                done++;
                wr_data = rand_data();
                wr_be   = {BW/32{32'($urandom())}};
            end
            waited++;
        end
        wr_valid = 1'b0;
        check("wr_burst_done", done, beats);
    endtask

    task automatic send_read(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                             input logic [TW-1:0] tag);
        int done;
        int waited;
        done   = 0;
        waited = 0;
        rd_addr  = addr;
        rd_size  = size;
        rd_tag   = tag;
        rd_valid = 1'b1;
        while (done == 0 && waited < 200) begin
            @(negedge clk);
            if (rd_ready) done = 1;
            cyc();
            waited++;
        end
        rd_valid = 1'b0;
        check("rd_accepted", done, 1);
    endtask

    task automatic return_beats(input int n);
        for (int i = 0; i < n; i++) begin
            avl_bus.avl_rdata_valid = 1'b1;
            avl_bus.avl_rdata       = rand_data();
            cyc();
        end
        avl_bus.avl_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        avl_bus.avl_rdata_valid = 1'b0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    // ---------------- directed tests ----------------
    bit toggle_en;
    int bad;
    int hit_cnt;

    initial begin
        wr_valid = 0; wr_addr = '0; wr_size = '0; wr_data = '0; wr_be = '0;
        rd_valid = 0; rd_addr = '0; rd_size = '0; rd_tag = '0;
        avl_bus.avl_ready = 1'b1;
        avl_bus.avl_rdata = '0;
        avl_bus.avl_rdata_valid = 1'b0;
        #1;
        do_reset();
        @(negedge clk);
        check("reset_state_idle", dbg_state, 0);
        check("reset_outstanding", dbg_outstanding, 0);
        cyc();

        // single 4-beat write at 0x100
        wr_addr = 29'h100; wr_size = 3'd4; wr_data = rand_data(); wr_be = '1; wr_valid = 1;
        @(negedge clk);
        check("t1_idle_cycle0", dbg_state, 0);
        check("t1_no_req_cycle0", avl_bus.avl_write_req, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_write_req", avl_bus.avl_write_req, 1);
            check("t1_burstbegin", avl_bus.avl_burstbegin, i == 0);
            check("t1_addr", avl_bus.avl_addr, 29'h100);
            check("t1_size", avl_bus.avl_size, 3'd4);
            cyc();
            if (i == 3) wr_valid = 0;
            else wr_data = rand_data();
        end
        @(negedge clk);
        check("t1_idle_cycle5", dbg_state, 0);
        check("t1_no_req_cycle5", avl_bus.avl_write_req, 0);
        cyc();

        // contention with avl_ready toggling
        do_reset();
        grant_log.delete();
        toggle_en = 1;
        fork
            begin
                fork
                    begin for (int i = 0; i < 3; i++) send_write(29'h400 + 29'(i * 2), 3'd2); end
                    begin for (int i = 0; i < 3; i++) send_read(29'h800 + 29'(i * 3), 3'd3, 8'(i)); end
                join
                toggle_en = 0;
            end
            begin
                while (toggle_en) begin
                    cyc();
                    avl_bus.avl_ready = ~avl_bus.avl_ready;
                end
            end
        join
        avl_bus.avl_ready = 1'b1;
        check("t2_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check("t2_grant_order", grant_log[i], (i % 2 == 0) ? G_W : G_R);
        return_beats(9);
        @(negedge clk);
        check("t2_drained", dbg_outstanding, 0);
        cyc();

        // FIFO full: 9 single-beat reads
        for (int i = 0; i < 8; i++) send_read(29'h1000 + 29'(i), 3'd1, 8'(i));
        @(negedge clk);
        check("t3_outstanding8", dbg_outstanding, 8);
        cyc();
        rd_addr = 29'h1008; rd_size = 3'd1; rd_tag = 8'd8; rd_valid = 1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd_ready) bad++;
            cyc();
        end
        check("t3_full_hold", bad, 0);
        avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
        @(negedge clk);
        check("t3_ret_valid", ret_valid, 1);
        check("t3_ret_tag0", ret_tag, 8'd0);
        check("t3_ret_last", ret_last, 1);
        check("t3_still_held", rd_ready, 0);
        cyc();
        avl_bus.avl_rdata_valid = 1'b0;
        @(negedge clk);
        check("t3_idle_after_pop", dbg_state, 0);
        cyc();
        @(negedge clk);
        check("t3_ninth_accept", rd_ready, 1);
        cyc();
        rd_valid = 0;
        return_beats(7);
        avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
        @(negedge clk);
        check("t3_last_tag8", ret_tag, 8'd8);
        cyc();
        avl_bus.avl_rdata_valid = 1'b0;

        // credit limit with size-7 reads
        for (int i = 0; i < 4; i++) send_read(29'h2000 + 29'(i * 8), 3'd7, 8'h10 + 8'(i));
        @(negedge clk);
        check("t4_outstanding28", dbg_outstanding, 28);
        check("t4_model_pin28", model_out, 28);
        cyc();
        rd_addr = 29'h2020; rd_size = 3'd7; rd_tag = 8'h14; rd_valid = 1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rd_ready) bad++;
            cyc();
        end
        check("t4_credit_hold", bad, 0);
        for (int i = 0; i < 3; i++) begin
            avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
            @(negedge clk);
            check("t4_ret_tag_cmd0", ret_tag, 8'h10);
            check("t4_ret_not_last", ret_last, 0);
            check("t4_held_on_return", rd_ready, 0);
            cyc();
        end
        avl_bus.avl_rdata_valid = 1'b0;
        hit_cnt = 0;
        for (int i = 0; i < 5 && hit_cnt == 0; i++) begin
            @(negedge clk);
            if (rd_ready) hit_cnt = 1;
            cyc();
        end
        rd_valid = 0;
        check("t4_issue_after_credit", hit_cnt, 1);
        @(negedge clk);
        check("t4_outstanding32", dbg_outstanding, 32);
        cyc();
        return_beats(3);
        avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
        @(negedge clk);
        check("t4_beat7_tag", ret_tag, 8'h10);
        check("t4_beat7_last", ret_last, 1);
        cyc();
        avl_bus.avl_rdata_valid = 1'b0;
        return_beats(28);
        @(negedge clk);
        check("t4_drained", dbg_outstanding, 0);
        cyc();

        // read issue coinciding with a return beat
        send_read(29'h3000, 3'd2, 8'h20);
        rd_addr = 29'h3010; rd_size = 3'd4; rd_tag = 8'h21; rd_valid = 1;
        @(negedge clk);
        check("t5_prior_out", dbg_outstanding, 2);
        check("t5_idle", rd_ready, 0);
        cyc();
        avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
        @(negedge clk);
        check("t5_issue_now", rd_ready, 1);
        check("t5_return_now", ret_valid, 1);
        cyc();
        rd_valid = 0;
        avl_bus.avl_rdata_valid = 1'b0;
        @(negedge clk);
        check("t5_net_update", dbg_outstanding, 5);
        cyc();
        return_beats(5);

        // size-0 commands
        rd_addr = 29'h4000; rd_size = 3'd0; rd_tag = 8'h30; rd_valid = 1;
        @(negedge clk);
        check("t6_rd0_err", err_size, 1);
        check("t6_rd0_ready", rd_ready, 1);
        check("t6_rd0_no_req", avl_bus.avl_read_req, 0);
        cyc();
        rd_valid = 0;
        @(negedge clk);
        check("t6_rd0_err_pulse", err_size, 0);
        check("t6_rd0_no_credit", dbg_outstanding, 0);
        cyc();
        wr_addr = 29'h4100; wr_size = 3'd0; wr_valid = 1;
        @(negedge clk);
        check("t6_wr0_err", err_size, 1);
        check("t6_wr0_ready", wr_ready, 1);
        check("t6_wr0_no_req", avl_bus.avl_write_req, 0);
        cyc();
        wr_valid = 0;

        // unexpected return beat
        avl_bus.avl_rdata_valid = 1'b1; avl_bus.avl_rdata = rand_data();
        @(negedge clk);
        check("t6_unexp_err", err_unexp, 1);
        check("t6_unexp_no_ret", ret_valid, 0);
        cyc();
        avl_bus.avl_rdata_valid = 1'b0;

        // reset in the middle of a write burst
        wr_addr = 29'h200; wr_size = 3'd4; wr_data = rand_data(); wr_be = '1; wr_valid = 1;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        check("t6_rst_write_req", avl_bus.avl_write_req, 0);
        check("t6_rst_wr_ready", wr_ready, 0);
        check("t6_rst_addr", avl_bus.avl_addr, 0);
        check("t6_rst_size", avl_bus.avl_size, 0);
        check("t6_rst_wdata", avl_bus.avl_wdata, 0);
        check("t6_rst_be", avl_bus.avl_be, 0);
        wr_valid = 0;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        wr_addr = 29'h300; wr_size = 3'd3; wr_data = rand_data(); wr_valid = 1;
        @(negedge clk);
        check("t6_post_rst_idle", dbg_state, 0);
        cyc();
        @(negedge clk);
        check("t6_post_rst_burstbegin", avl_bus.avl_burstbegin, 1);
        check("t6_post_rst_addr", avl_bus.avl_addr, 29'h300);
        cyc();
        wr_data = rand_data();
        @(negedge clk);
        check("t6_post_rst_beat1", avl_bus.avl_burstbegin, 0);
        cyc();
        wr_data = rand_data();
        @(negedge clk);
        cyc();
        wr_valid = 0;
        @(negedge clk);
        check("t6_post_rst_done", dbg_state, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
